// File: rtl/drag_pkg.sv
// Shared drag-race definitions: state encoding, fixed-point format and screen geometry
// so that both players' car instances and the overlay stage agree.
package drag_pkg;

   localparam int unsigned FRAC_BITS       = 4;
   localparam int unsigned SCREEN_X_FINISH = 1000;
   localparam int unsigned LANE_Y_P1       = 400;
   localparam int unsigned LANE_Y_P2       = 440;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_RACE      = 2'd2,
      ST_FINISH    = 2'd3
   } state_e;

endpackage

// File: rtl/frame_tick.sv
// One-cycle pulse on the rising edge of vertical blanking. The delayed copy resets high
// so a blanking level present at reset release does not produce a tick.
module frame_tick (
   input  logic clk,
   input  logic rst,
   input  logic vblnk_in,
   output logic tick
);

   logic vblnk_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_d <= 1'b1;
      end else begin
         vblnk_d <= vblnk_in;
      end
   end

   assign tick = vblnk_in & ~vblnk_d;

endmodule

// File: rtl/car_motion.sv
// Per-player car kinematics: idle -> countdown -> race -> finish, integrating an 8.4 speed
// into an 11.4 position once per frame and driving the sprite overlay pointers.
module car_motion
   import drag_pkg::*;
#(
   parameter int unsigned X_START          = 32,
   parameter int unsigned Y_LANE           = LANE_Y_P1,
   parameter int unsigned X_FINISH         = SCREEN_X_FINISH,
   parameter int unsigned COUNTDOWN_FRAMES = 180,
   parameter int unsigned ACCEL            = 2,
   parameter int unsigned DRAG             = 1,
   parameter int unsigned MAX_SPEED        = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk_in,
   input  logic        start,
   input  logic        gas,
   output logic [10:0] x_pointer,
   output logic [10:0] y_pointer,
   output logic [1:0]  state,
   output logic        finished,
   output logic        false_start,
   output logic [15:0] race_frames
);

   localparam logic [14:0] POS_START  = 15'(X_START << FRAC_BITS);
   localparam logic [14:0] POS_FINISH = 15'(X_FINISH << FRAC_BITS);
   localparam logic [10:0] X_FIN_PX   = 11'(X_FINISH);
   localparam logic [12:0] ACCEL_W    = 13'(ACCEL);
   localparam logic [11:0] DRAG_W     = 12'(DRAG);
   localparam logic [12:0] MAX_W      = 13'(MAX_SPEED);
   localparam logic [7:0]  CNT_INIT   = 8'(COUNTDOWN_FRAMES);

   state_e      state_q, state_d;
   logic [11:0] speed_q, speed_d, speed_new;
   logic [14:0] pos_q, pos_d, pos_new;
   logic [12:0] speed_sum;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] frames_q, frames_d;
   logic        finished_q, finished_d;
   logic        false_start_q, false_start_d;
   logic        tick;
   logic        restart;

   frame_tick u_frame_tick (
      .clk      (clk),
      .rst      (rst),
      .vblnk_in (vblnk_in),
      .tick     (tick)
   );

   // Speed clamp uses a 13-bit sum so the ceiling compare sees any carry.
   always_comb begin
      speed_sum = {1'b0, speed_q} + ACCEL_W;
      if (gas) begin
         speed_new = (speed_sum > MAX_W) ? MAX_W[11:0] : speed_sum[11:0];
      end else begin
         speed_new = (speed_q > DRAG_W) ? speed_q - DRAG_W : 12'd0;
      end
      pos_new = pos_q + {3'b000, speed_new};
   end

   always_comb begin
      state_d       = state_q;
      speed_d       = speed_q;
      pos_d         = pos_q;
      cnt_d         = cnt_q;
      frames_d      = frames_q;
      finished_d    = finished_q;
      false_start_d = false_start_q;
      restart       = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_FINISH: restart = start;
         ST_COUNTDOWN: begin
            if (tick) begin
               if (gas) begin
                  state_d       = ST_FINISH;
                  false_start_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 8'd1;
                  if (cnt_q == 8'd1) begin
                     state_d = ST_RACE;
                  end
               end
            end
         end
         ST_RACE: begin
            if (tick) begin
               speed_d = speed_new;
               pos_d   = pos_new;
               if (frames_q != 16'hFFFF) begin
                  frames_d = frames_q + 16'd1;
               end
               if (pos_new[14:4] >= X_FIN_PX) begin
                  pos_d      = POS_FINISH;
                  speed_d    = 12'd0;
                  state_d    = ST_FINISH;
                  finished_d = 1'b1;
               end
            end
         end
         default: ;
      endcase

      // A start request overrides any coincident frame tick.
      if (restart) begin
         state_d       = ST_COUNTDOWN;
         cnt_d         = CNT_INIT;
         pos_d         = POS_START;
         speed_d       = 12'd0;
         frames_d      = 16'd0;
         finished_d    = 1'b0;
         false_start_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         speed_q       <= 12'd0;
         pos_q         <= POS_START;
         cnt_q         <= 8'd0;
         frames_q      <= 16'd0;
         finished_q    <= 1'b0;
         false_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         speed_q       <= speed_d;
         pos_q         <= pos_d;
         cnt_q         <= cnt_d;
         frames_q      <= frames_d;
         finished_q    <= finished_d;
         false_start_q <= false_start_d;
      end
   end

   assign x_pointer   = pos_q[14:4];
   assign y_pointer   = 11'(Y_LANE);
   assign state       = state_q;
   assign finished    = finished_q;
   assign false_start = false_start_q;
   assign race_frames = frames_q;

endmodule

// File: tb/tb_car_motion.sv
// Bench for car_motion: directed scenarios with literal expectations plus a randomized run,
// with every cycle compared against a frame-level behavioural model.
module tb_car_motion;

   localparam int X_START   = 32;
   localparam int Y_LANE    = 400;
   localparam int X_FINISH  = 1000;
   localparam int CD_FRAMES = 180;

   logic        clk = 1'b0;
   logic        rst, vblnk_in, start, gas;
   logic [10:0] x_pointer, y_pointer;
   logic [1:0]  state;
   logic        finished, false_start;
   logic [15:0] race_frames;

   int vectors     = 0;
   int miscompares = 0;

   car_motion dut (
      .clk         (clk),
      .rst         (rst),
      .vblnk_in    (vblnk_in),
      .start       (start),
      .gas         (gas),
      .x_pointer   (x_pointer),
      .y_pointer   (y_pointer),
      .state       (state),
      .finished    (finished),
      .false_start (false_start),
      .race_frames (race_frames)
   );

   always #5 clk = ~clk;

   // Frame-level model: state as a number, plain integer kinematics in 1/16 px units.
   int m_state, m_speed, m_pos, m_frames, m_fin, m_fs, m_cd_ticks;
   bit m_vprev;

   always @(posedge clk) begin : model
      int s, sp, p, rf, fin, fs, cd;
      bit tk;
      s = m_state; sp = m_speed; p = m_pos; rf = m_frames;
      fin = m_fin; fs = m_fs; cd = m_cd_ticks;
      if (rst) begin
         s = 0; sp = 0; p = X_START * 16; rf = 0; fin = 0; fs = 0; cd = 0;
         m_vprev <= 1'b1;
      end else begin
         tk = vblnk_in && !m_vprev;
         m_vprev <= vblnk_in;
         if ((s == 0 || s == 3) && start) begin
            s = 1; cd = 0; sp = 0; p = X_START * 16; rf = 0; fin = 0; fs = 0;
         end else if (s == 1 && tk) begin
            if (gas) begin
               s = 3; fs = 1;
            end else begin
               cd = cd + 1;
               if (cd == CD_FRAMES) s = 2;
            end
         end else if (s == 2 && tk) begin
            if (gas) sp = (sp + 2 > 256) ? 256 : sp + 2;
            else     sp = (sp > 1) ? sp - 1 : 0;
            p = p + sp;
            if (rf < 65535) rf = rf + 1;
            if (p / 16 >= X_FINISH) begin
               p = X_FINISH * 16; sp = 0; s = 3; fin = 1;
            end
         end
      end
      m_state <= s; m_speed <= sp; m_pos <= p; m_frames <= rf;
      m_fin <= fin; m_fs <= fs; m_cd_ticks <= cd;
   end

   always @(posedge clk) begin : compare
      #1;
      vectors++;
      if (x_pointer !== 11'(m_pos / 16) || y_pointer !== 11'(Y_LANE) ||
          state !== 2'(m_state) || finished !== 1'(m_fin) ||
          false_start !== 1'(m_fs) || race_frames !== 16'(m_frames)) begin
         miscompares++;
         $display("FAIL model t=%0t: x=%0d/%0d y=%0d/%0d st=%0d/%0d fin=%0d/%0d fs=%0d/%0d rf=%0d/%0d",
                  $time, x_pointer, m_pos / 16, y_pointer, Y_LANE, state, m_state,
                  finished, m_fin, false_start, m_fs, race_frames, m_frames);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // All driving happens on falling edges; each frame is a 1-cycle blanking pulse, period 4.
   task automatic tick();
      vblnk_in = 1'b1;
      @(negedge clk);
      vblnk_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic start_with_tick();
      start    = 1'b1;
      vblnk_in = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      vblnk_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic random_phase(input int frames);
      int hi, lo;
      for (int i = 0; i < frames; i++) begin
         hi = $urandom_range(1, 3);
         lo = $urandom_range(1, 5);
         if (m_state == 1) gas = ($urandom_range(0, 199) == 0);
         else              gas = ($urandom_range(0, 9) < 7);
         start    = ($urandom_range(0, 59) == 0);
         rst      = ($urandom_range(0, 799) == 0);
         vblnk_in = ($urandom_range(0, 9) != 0);
         @(negedge clk);
         start = 1'b0;
         rst   = 1'b0;
         repeat (hi - 1) @(negedge clk);
         vblnk_in = 1'b0;
         if (m_state == 2 && $urandom_range(0, 3) == 0) gas = ~gas;
         repeat (lo) @(negedge clk);
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst = 1'b1; vblnk_in = 1'b0; start = 1'b0; gas = 1'b0;
      @(negedge clk);

      // Reset held with blanking toggling
      ticks(5);
      check("rst_x", x_pointer, 32);
      check("rst_y", y_pointer, 400);
      check("rst_state", state, 0);
      rst = 1'b0;
      ticks(5);
      check("idle_state", state, 0);
      check("idle_x", x_pointer, 32);

      // Countdown lasts exactly 180 frames
      pulse_start();
      check("cd_enter", state, 1);
      ticks(179);
      check("cd_179", state, 1);
      check("cd_x", x_pointer, 32);
      tick();
      check("cd_green", state, 2);
      check("cd_green_rf", race_frames, 0);

      // Full-throttle run to the line
      gas = 1'b1;
      ticks(4);
      check("acc_x4", x_pointer, 33);
      check("acc_rf4", race_frames, 4);
      ticks(6);
      check("acc_x10", x_pointer, 38);
      ticks(113);
      check("fin_123_state", state, 2);
      tick();
      check("fin_state", state, 3);
      check("fin_flag", finished, 1);
      check("fin_x", x_pointer, 1000);
      check("fin_rf", race_frames, 124);
      check("fin_fs", false_start, 0);
      ticks(5);
      check("fin_hold_x", x_pointer, 1000);
      check("fin_hold_rf", race_frames, 124);
      gas = 1'b0;

      // False start on countdown frame 50
      pulse_start();
      check("fs_restart", state, 1);
      check("fs_restart_fin", finished, 0);
      check("fs_restart_x", x_pointer, 32);
      ticks(49);
      gas = 1'b1;
      tick();
      gas = 1'b0;
      check("fs_state", state, 3);
      check("fs_flag", false_start, 1);
      check("fs_fin", finished, 0);
      check("fs_x", x_pointer, 32);

      // Coast from speed 20 down to standstill
      pulse_start();
      ticks(180);
      check("coast_race", state, 2);
      gas = 1'b1;
      ticks(10);
      gas = 1'b0;
      check("coast_x0", x_pointer, 38);
      ticks(20);
      check("coast_x20", x_pointer, 50);
      check("coast_rf", race_frames, 30);
      ticks(3);
      check("coast_stop_x", x_pointer, 50);
      pulse_start();
      check("race_start_ignored", state, 2);

      // Reset mid-race takes effect on the very next edge
      gas = 1'b1;
      ticks(2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_state", state, 0);
      check("mid_rst_x", x_pointer, 32);
      check("mid_rst_rf", race_frames, 0);
      @(negedge clk);
      rst = 1'b0;
      gas = 1'b0;

      // Start coinciding with a frame tick, from IDLE then from FINISH
      start_with_tick();
      check("idle_coinc_state", state, 1);
      ticks(179);
      check("idle_coinc_179", state, 1);
      tick();
      check("idle_coinc_green", state, 2);
      gas = 1'b1;
      ticks(124);
      check("fin2_state", state, 3);
      gas = 1'b0;
      start_with_tick();
      check("fin_coinc_state", state, 1);
      check("fin_coinc_x", x_pointer, 32);
      check("fin_coinc_fin", finished, 0);
      ticks(179);
      check("fin_coinc_179", state, 1);
      tick();
      check("fin_coinc_green", state, 2);

      random_phase(2500);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
